// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the 74F153 scan controller.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        FIN  = 2'b10
    } state_e;

    localparam int NSTEP    = 4;
    localparam int SETTLE_W = 4;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the scan controller, the 74F153 it drives and its consumer.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic             START;
    logic             Ya;
    logic             Yb;
    logic             S0;
    logic             S1;
    logic             Ea_N;
    logic             Eb_N;
    logic [NSTEP-1:0] Qa;
    logic [NSTEP-1:0] Qb;
    logic             BUSY;
    logic             DONE;

    modport master (
        input  START, Ya, Yb,
        output S0, S1, Ea_N, Eb_N, Qa, Qb, BUSY, DONE
    );

    modport slave (
        output START, Ya, Yb,
        input  S0, S1, Ea_N, Eb_N, Qa, Qb, BUSY, DONE
    );

endinterface

// File: rtl/mux_scan_ctrl_settle_cnt.sv
// Loadable 4-bit down-counter; TC marks the last settle cycle of a step.
module settle_cnt
    import mux_scan_pkg::*;
(
    input  logic                CP,
    input  logic                MR_N,
    input  logic                LD,
    input  logic [SETTLE_W-1:0] D,
    input  logic                EN,
    output logic [SETTLE_W-1:0] Q,
    output logic                TC
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (LD) begin
            cnt_d = D;
        end else if (EN) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q  = cnt_q;
    assign TC = (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 74F153 through all four selects, samples Ya/Yb after SETTLE cycles
// per step and publishes the assembled 4-bit words with a one-cycle DONE.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic            CP,
    input  logic            MR_N,
    mux_scan_ctrl_if.master bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);
    localparam logic [1:0]          LAST_IDX = 2'(NSTEP - 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [NSTEP-1:0] shA_q, shA_d;
    logic [NSTEP-1:0] shB_q, shB_d;
    logic [NSTEP-1:0] qa_q, qa_d;
    logic [NSTEP-1:0] qb_q, qb_d;

    logic                cntLd;
    logic                cntEn;
    logic                capture;
    logic [SETTLE_W-1:0] cntQ_unused;

    settle_cnt u_settle_cnt (
        .CP (CP),
        .MR_N (MR_N),
        .LD (cntLd),
        .D  (SETTLE_V),
        .EN (cntEn),
        .Q  (cntQ_unused),
        .TC (capture)
    );

    // The last step bypasses shadow storage so Qa/Qb update on the final capture edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shA_d   = shA_q;
        shB_d   = shB_q;
        qa_d    = qa_q;
        qb_d    = qb_q;
        cntLd   = 1'b0;
        cntEn   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    idx_d   = 2'd0;
                    cntLd   = 1'b1;
                    state_d = STEP;
                end
            end
            STEP: begin
                cntEn = 1'b1;
                if (capture) begin
                    shA_d[idx_q] = bus.Ya;
                    shB_d[idx_q] = bus.Yb;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 2'd1;
                        cntLd = 1'b1;
                    end else begin
                        qa_d    = {bus.Ya, shA_q[2:0]};
                        qb_d    = {bus.Yb, shB_q[2:0]};
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shA_q   <= '0;
            shB_q   <= '0;
            qa_q    <= '0;
            qb_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shA_q   <= shA_d;
            shB_q   <= shB_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
        end
    end

    // Mux controls decode from registered state only; Ya/Yb never reach outputs directly.
    assign bus.S0   = (state_q == STEP) & idx_q[0];
    assign bus.S1   = (state_q == STEP) & idx_q[1];
    assign bus.Ea_N = (state_q != STEP);
    assign bus.Eb_N = (state_q != STEP);
    assign bus.BUSY = (state_q == STEP);
    assign bus.DONE = (state_q == FIN);
    assign bus.Qa   = qa_q;
    assign bus.Qb   = qb_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench: two controllers (SETTLE=1 and SETTLE=3) each driving a behavioural 74F153.
module tb_mux_scan_ctrl;

    logic CP   = 1'b0;
    logic MR_N = 1'b0;

    always #5 CP = ~CP;

    mux_scan_ctrl_if bus1 ();
    mux_scan_ctrl_if bus3 ();

    logic [3:0] ia1, ib1, ia3, ib3;

    // 74F153 model: enabled output follows the selected input, disabled output is low.
    assign bus1.Ya = ~bus1.Ea_N & ia1[{bus1.S1, bus1.S0}];
    assign bus1.Yb = ~bus1.Eb_N & ib1[{bus1.S1, bus1.S0}];
    assign bus3.Ya = ~bus3.Ea_N & ia3[{bus3.S1, bus3.S0}];
    assign bus3.Yb = ~bus3.Eb_N & ib3[{bus3.S1, bus3.S0}];

    mux_scan_ctrl #(.SETTLE(1)) dut1 (.CP(CP), .MR_N(MR_N), .bus(bus1));
    mux_scan_ctrl #(.SETTLE(3)) dut3 (.CP(CP), .MR_N(MR_N), .bus(bus3));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] ia;
        logic [3:0] ib;
        logic [3:0] expA;
        logic [3:0] expB;
    } vec_t;

    vec_t vecs [4];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setStart(input int which, input logic v);
        if (which == 1) bus1.START = v;
        else            bus3.START = v;
    endtask

    task automatic sampleBus(input int which, output logic busy, output logic done,
                             output logic ean, output logic ebn, output logic [1:0] sel,
                             output logic [3:0] qa, output logic [3:0] qb);
        if (which == 1) begin
            busy = bus1.BUSY; done = bus1.DONE; ean = bus1.Ea_N; ebn = bus1.Eb_N;
            sel = {bus1.S1, bus1.S0}; qa = bus1.Qa; qb = bus1.Qb;
        end else begin
            busy = bus3.BUSY; done = bus3.DONE; ean = bus3.Ea_N; ebn = bus3.Eb_N;
            sel = {bus3.S1, bus3.S0}; qa = bus3.Qa; qb = bus3.Qb;
        end
    endtask

    task automatic checkIdle(input int which, input logic [3:0] expA, input logic [3:0] expB);
        logic busy, done, ean, ebn;
        logic [1:0] sel;
        logic [3:0] qa, qb;
        sampleBus(which, busy, done, ean, ebn, sel, qa, qb);
        checkOutput("idle BUSY", 8'(busy), 8'd0);
        checkOutput("idle DONE", 8'(done), 8'd0);
        checkOutput("idle Ea_N", 8'(ean), 8'd1);
        checkOutput("idle Eb_N", 8'(ebn), 8'd1);
        checkOutput("idle S1S0", 8'(sel), 8'd0);
        checkOutput("idle Qa", 8'(qa), 8'(expA));
        checkOutput("idle Qb", 8'(qb), 8'(expB));
    endtask

    // One full scan: pulse START, then check every cycle through DONE and back to IDLE.
    task automatic applyStimulus(input int which, input int settle,
                                 input logic [3:0] prevA, input logic [3:0] prevB,
                                 input logic [3:0] newA, input logic [3:0] newB);
        logic busy, done, ean, ebn;
        logic [1:0] sel;
        logic [3:0] qa, qb;
        int last;
        last = 4 * settle;
        @(negedge CP);
        setStart(which, 1'b1);
        @(posedge CP);
        #1;
        setStart(which, 1'b0);
        for (int k = 0; k <= last + 1; k++) begin
            @(negedge CP);
            sampleBus(which, busy, done, ean, ebn, sel, qa, qb);
            checkOutput("scan BUSY", 8'(busy), (k < last) ? 8'd1 : 8'd0);
            checkOutput("scan DONE", 8'(done), (k == last) ? 8'd1 : 8'd0);
            checkOutput("scan S1S0", 8'(sel), (k < last) ? 8'(k / settle) : 8'd0);
            checkOutput("scan Ea_N", 8'(ean), (k < last) ? 8'd0 : 8'd1);
            checkOutput("scan Eb_N", 8'(ebn), (k < last) ? 8'd0 : 8'd1);
            checkOutput("scan Qa", 8'(qa), (k >= last) ? 8'(newA) : 8'(prevA));
            checkOutput("scan Qb", 8'(qb), (k >= last) ? 8'(newB) : 8'(prevB));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic busy, done, ean, ebn;
        logic [1:0] sel;
        logic [3:0] qa, qb;
        logic [3:0] prevA, prevB;

        bus1.START = 1'b0;
        bus3.START = 1'b0;
        ia1 = 4'b0101; ib1 = 4'b1010;
        ia3 = 4'b0101; ib3 = 4'b1010;

        vecs[0] = '{4'b0101, 4'b1010, 4'b0101, 4'b1010};
        vecs[1] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
        vecs[2] = '{4'b1001, 4'b0110, 4'b1001, 4'b0110};
        vecs[3] = '{4'b0101, 4'b1010, 4'b0101, 4'b1010};

        MR_N = 1'b0;
        #12;
        checkIdle(1, 4'b0000, 4'b0000);
        checkIdle(3, 4'b0000, 4'b0000);
        @(negedge CP);
        MR_N = 1'b1;

        $display("[TB] SETTLE=3 scan");
        applyStimulus(3, 3, 4'b0000, 4'b0000, 4'b0101, 4'b1010);

        $display("[TB] SETTLE=1 table scans");
        prevA = 4'b0000;
        prevB = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            ia1 = vecs[i].ia;
            ib1 = vecs[i].ib;
            applyStimulus(1, 1, prevA, prevB, vecs[i].expA, vecs[i].expB);
            prevA = vecs[i].expA;
            prevB = vecs[i].expB;
        end

        $display("[TB] data change between scans");
        ia1 = 4'b0011; ib1 = 4'b1100;
        applyStimulus(1, 1, 4'b0101, 4'b1010, 4'b0011, 4'b1100);

        $display("[TB] START held high");
        ia1 = 4'b0101; ib1 = 4'b1010;
        @(negedge CP);
        bus1.START = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(posedge CP);
            @(negedge CP);
            sampleBus(1, busy, done, ean, ebn, sel, qa, qb);
            checkOutput("held BUSY", 8'(busy), ((k % 6) < 4) ? 8'd1 : 8'd0);
            checkOutput("held DONE", 8'(done), ((k % 6) == 4) ? 8'd1 : 8'd0);
            checkOutput("held S1S0", 8'(sel), ((k % 6) < 4) ? 8'(k % 6) : 8'd0);
            checkOutput("held Qa", 8'(qa), (k >= 4) ? 8'h05 : 8'h03);
        end
        bus1.START = 1'b0;

        $display("[TB] reset mid-scan");
        ia1 = 4'b1111; ib1 = 4'b1111;
        @(negedge CP);
        bus1.START = 1'b1;
        @(posedge CP);
        #1;
        bus1.START = 1'b0;
        repeat (3) @(negedge CP);
        sampleBus(1, busy, done, ean, ebn, sel, qa, qb);
        checkOutput("pre-reset S1S0", 8'(sel), 8'd2);
        checkOutput("pre-reset Qa", 8'(qa), 8'h05);
        #2;
        MR_N = 1'b0;
        #1;
        checkIdle(1, 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge CP);
            sampleBus(1, busy, done, ean, ebn, sel, qa, qb);
            checkOutput("reset DONE", 8'(done), 8'd0);
            checkOutput("reset Qa", 8'(qa), 8'd0);
        end
        MR_N = 1'b1;
        @(negedge CP);
        checkIdle(1, 4'b0000, 4'b0000);
        applyStimulus(1, 1, 4'b0000, 4'b0000, 4'b1111, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer and capture stage wrapped around a part_74F153 dual 4-to-1 multiplexer. On a START request it drives the mux select lines S1:S0 through 0..3 and holds the active-low enables low. After a programmable settle time per step it samples the mux outputs Ya/Yb, and presents the two assembled 4-bit words on Qa/Qb with a one-cycle DONE strobe. It is the control-plus-consumer stage directly downstream of the 74F153: it drives that part's S0, S1, Ea_N and Eb_N, and consumes its Ya and Yb.

## Interface
- SETTLE, default 1: clock cycles each select value is held before sampling; legal range 1..15.

Ports (name, direction, width, meaning):
- CP  in  1  clock; all state changes on the rising edge.
- MR_N  in  1  master reset; asynchronous, active-low.
- START  in  1  scan request; sampled only in IDLE.
- Ya  in  1  74F153 output a.
- Yb  in  1  74F153 output b.
- S0  out  1  mux select bit 0; LSB of the current step index.
- S1  out  1  mux select bit 1; MSB of the current step index.
- Ea_N  out  1  mux enable a, active-low.
- Eb_N  out  1  mux enable b, active-low; always equal to Ea_N.
- Qa  out  4  captured word from Ya; bit i is the sample taken with select = i.
- Qb  out  4  captured word from Yb; same bit ordering as Qa.
- BUSY  out  1  high while a scan is in progress.
- DONE  out  1  single-cycle strobe: Qa/Qb have just been updated.

## Operation
- States: IDLE, STEP, FIN.
  - IDLE:
    - Ea_N = Eb_N = 1, S1:S0 = 00, BUSY = 0.
    - START = 1 at an edge: load idx = 0, load settle count = SETTLE, go to STEP.
  - STEP:
    - Ea_N = Eb_N = 0, S1:S0 = idx, BUSY = 1.
    - Settle count decrements each edge.
    - At the edge where the count equals 1: capture Ya into shadow_a[idx] and Yb into shadow_b[idx].
    - After that capture, if idx < 3: increment idx, reload count to SETTLE, stay in STEP.
    - If idx = 3: write Qa = {Ya, shadow_a[2:0]} and Qb = {Yb, shadow_b[2:0]}, then go to FIN.
  - FIN:
    - DONE = 1, BUSY = 0, Ea_N = Eb_N = 1, S1:S0 = 00.
    - Next edge goes to IDLE unconditionally; START is ignored in FIN.
- START while BUSY is ignored. There is no queuing.
- Qa/Qb change only at the final capture edge. They hold their value across IDLE, FIN and subsequent scans until the next final capture.
- Reset (MR_N = 0), applied at any time including mid-scan:
  - State goes to IDLE.
  - idx, settle count, shadow_a and shadow_b go to 0.
  - Outputs: Qa = Qb = 0, DONE = 0, BUSY = 0, S1:S0 = 00, Ea_N = Eb_N = 1.
  - A partial scan is discarded and Qa/Qb do not update.
- Release of MR_N takes effect at the first rising edge after deassertion.
- All outputs are registered or decoded from registered state only. Ya/Yb never reach outputs combinationally.

## Timing
- Let edge 0 be the edge that samples START = 1 in IDLE.
- After edge 0: S1:S0 = 00, enables low, BUSY = 1.
- Capture of idx i happens at edge SETTLE*(i+1).
- Select changes to i+1 on that same edge, so each select value is stable for exactly SETTLE cycles before it is sampled.
- Final capture and Qa/Qb update occur at edge 4*SETTLE. DONE is high from edge 4*SETTLE to edge 4*SETTLE+1.
- Earliest next START sample is at edge 4*SETTLE+2. Minimum scan period is 4*SETTLE+2 cycles.
- SETTLE = 1: 4 capture cycles, DONE in cycle 5, scan period 6.
- Ya/Yb must be stable at each capture edge. The 74F153 propagation delay must fit within SETTLE cycles; that is the purpose of SETTLE.

## Structure
- Shared package mux_scan_pkg holds:
  - state encoding: IDLE = 2'b00, STEP = 2'b01, FIN = 2'b10;
  - step-count constant NSTEP = 4;
  - SETTLE width constant (4 bits).
- One sub-module, settle_cnt: a 4-bit loadable down-counter.
  - Ports: CP, MR_N, LD, D, EN, Q.
  - Output TC is high when Q = 1.
  - The FSM uses TC as the capture strobe.
- Top level contains the FSM, the idx register, the shadow registers and the output registers.

## Test plan
- Basic scan: connect to part_74F153 with {I3a..I0a} = 0101 and {I3b..I0b} = 1010, SETTLE = 1, pulse START. Expect:
  - S1:S0 sequence 00, 01, 10, 11, with Ea_N/Eb_N low for 4 cycles;
  - DONE at cycle 5;
  - Qa = 0101, Qb = 1010.
- SETTLE = 3: same data. Each select held 3 cycles, DONE at cycle 13, Qa = 0101, Qb = 1010.
- START held high continuously, SETTLE = 1:
  - scans start at edges 0, 6, 12;
  - DONE pulses are exactly one cycle wide;
  - no START is accepted during STEP or FIN.
- Reset mid-scan: assert MR_N at step 2 of a scan loading 1111/1111 after a previous result of 0101/1010. Expect:
  - all outputs reach reset values immediately, asynchronously;
  - Qa = Qb = 0000;
  - no DONE pulse;
  - a fresh START then yields 1111/1111.
- Data change between scans: change the inputs to 0011/1100 after DONE and rescan. Qa/Qb hold 0101/1010 until the final capture edge, then become 0011/1100 in the DONE cycle.
